// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice walked over WIDTH cycles, LSB first,
// with start/busy/done handshake and registered sum, carry-out and signed overflow.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] opa, opa_n;
   logic [WIDTH-1:0] opb, opb_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0] sum_n;
   logic             carry, carry_n;
   logic             cout_n, ovf_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             s_bit, co_bit;

   // Next-state and datapath update; one adder slice shared across all bits
   always_comb begin
      state_n = state;
      opa_n   = opa;
      opb_n   = opb;
      acc_n   = acc;
      carry_n = carry;
      cnt_n   = cnt;
      sum_n   = sum;
      cout_n  = cout;
      ovf_n   = ovf;
      s_bit   = opa[0] ^ opb[0] ^ carry;
      co_bit  = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

      case (state)
         IDLE: begin
            if (start) begin
               opa_n   = a;
               opb_n   = b;
               carry_n = cin;
               cnt_n   = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            carry_n = co_bit;
            opa_n   = opa >> 1;
            opb_n   = opb >> 1;
            acc_n   = (acc >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
            cnt_n   = cnt + CW'(1);
            // Last bit: carry still holds the carry into the MSB here
            if (cnt == CW'(WIDTH - 1)) begin
               sum_n   = acc_n;
               cout_n  = co_bit;
               ovf_n   = carry ^ co_bit;
               state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, datapath and output registers; busy/done registered from next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         opa   <= opa_n;
         opb   <= opb_n;
         acc   <= acc_n;
         carry <= carry_n;
         cnt   <= cnt_n;
         sum   <= sum_n;
         cout  <= cout_n;
         ovf   <= ovf_n;
         busy  <= (state_n == RUN);
         done  <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, cin8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       start1, cin1, busy1, done1, cout1, ovf1;
   logic [0:0] a1, b1, sum1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one operation and watch it to completion (bounded)
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       output logic [7:0] s, output logic co, output logic ov,
                       output int nbusy, output int ndone, output logic done_after);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = 8'hA5; b8 = 8'hC3; cin8 = 1'b1;
      nbusy = 0; ndone = 0; s = 'x; co = 1'bx; ov = 1'bx;
      for (int i = 0; i < 20; i++) begin
         if (busy8) nbusy++;
         if (done8) begin
            ndone++;
            s = sum8; co = cout8; ov = ovf8;
            break;
         end
         tick();
      end
      tick();
      done_after = done8;
   endtask

   initial begin
      logic [7:0] s;
      logic       co, ov, da;
      logic [8:0] ref9;
      logic [1:0] ref2;
      int         nb, nd;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      tick(); tick();
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_out", {22'd0, sum8, cout8, ovf8}, 32'd0);
      chk("rst_w1", {27'd0, busy1, done1, sum1, cout1, ovf1}, 32'd0);
      rst = 1'b0;
      tick();

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run8(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, nb, nd, da);
         chk($sformatf("v%0d_sum", i), 32'(s), 32'(vecs[i].sum));
         chk($sformatf("v%0d_cout", i), 32'(co), 32'(vecs[i].cout));
         chk($sformatf("v%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
         chk($sformatf("v%0d_busycyc", i), 32'(nb), 32'd8);
         chk($sformatf("v%0d_donecnt", i), 32'(nd), 32'd1);
         chk($sformatf("v%0d_donewidth", i), 32'(da), 32'd0);
      end

      // Starts during RUN (busy cycles 3 and 8) are ignored
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      nb = 0; nd = 0; s = 'x;
      for (int c = 1; c <= 14; c++) begin
         if (busy8) nb++;
         if (done8) begin nd++; s = sum8; end
         start8 = (c == 3 || c == 8);
         a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
         tick();
      end
      start8 = 1'b0;
      chk("ign_donecnt", 32'(nd), 32'd1);
      chk("ign_busycyc", 32'(nb), 32'd8);
      chk("ign_sum", 32'(s), 32'h01);
      chk("ign_hold", {23'd0, sum8, cout8}, {23'd0, 8'h01, 1'b0});

      // Reset mid-operation: outputs clear, no done, then a fresh start works
      run8(8'h5A, 8'h3C, 1'b0, s, co, ov, nb, nd, da);
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      chk("rmid_busy4", 32'(busy8), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rmid_busy", 32'(busy8), 32'd0);
      chk("rmid_done", 32'(done8), 32'd0);
      chk("rmid_out", {22'd0, sum8, cout8, ovf8}, 32'd0);
      nd = 0;
      for (int c = 0; c < 12; c++) begin
         if (done8 || busy8) nd++;
         tick();
      end
      chk("rmid_quiet", 32'(nd), 32'd0);
      run8(8'h12, 8'h34, 1'b0, s, co, ov, nb, nd, da);
      chk("rmid_fresh_sum", 32'(s), 32'h46);

      // Random operands against an arithmetic reference
      for (int i = 0; i < 200; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         ref9 = 9'(ra) + 9'(rb) + 9'(rc);
         run8(ra, rb, rc, s, co, ov, nb, nd, da);
         chk($sformatf("rnd%0d_sum", i), 32'(s), 32'(ref9[7:0]));
         chk($sformatf("rnd%0d_cout", i), 32'(co), 32'(ref9[8]));
         chk($sformatf("rnd%0d_ovf", i), 32'(ov),
             32'((ra[7] == rb[7]) && (ref9[7] != ra[7])));
      end

      // WIDTH=1: full-adder truth table, done two cycles after start is sampled
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv = 3'(v);
         ref2 = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
         a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; start1 = 1'b1;
         tick();
         start1 = 1'b0;
         chk($sformatf("w1_%0d_busy", v), {30'd0, busy1, done1}, 32'b10);
         tick();
         chk($sformatf("w1_%0d_done", v), {30'd0, busy1, done1}, 32'b01);
         chk($sformatf("w1_%0d_sum", v), 32'(sum1), 32'(ref2[0]));
         chk($sformatf("w1_%0d_cout", v), 32'(cout1), 32'(ref2[1]));
         chk($sformatf("w1_%0d_ovf", v), 32'(ovf1), 32'(vv[0] ^ ref2[1]));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial addition controller. Sequences one full-adder slice (s = a^b^c, co = majority(a,b,c)) over WIDTH cycles, LSB first, with a registered carry.
- Accepts operands on a start pulse, reports busy, then pulses done with the registered sum, carry-out and signed overflow.
- Time-multiplexes one adder slice in area-constrained datapaths. Also serves as the sequential stimulus/checker target for the full-adder benches.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid and updated.
- sum  output  WIDTH  registered result of a+b+cin (mod 2^WIDTH).
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: rst high at a clk edge forces state=IDLE and clears all internal registers. Outputs clear to busy=0, done=0, sum=0, cout=0, ovf=0. Reset overrides every other input and aborts an in-flight operation with no done pulse.
- State machine states: IDLE, RUN, DONE.
- IDLE: when start=1 at an edge:
  - Load shift registers opa<=a, opb<=b, carry<=cin, bit counter cnt<=0.
  - Move to RUN.
- IDLE, otherwise: hold.
- RUN: each edge processes bit cnt:
  - s_bit = opa[0]^opb[0]^carry.
  - carry <= majority(opa[0], opb[0], carry).
  - opa and opb shift right by 1.
  - s_bit shifts into an internal accumulator from the MSB side.
  - cnt <= cnt+1.
  - At the edge where cnt==WIDTH-1, also load the outputs and move to DONE:
    - sum <= final accumulator.
    - cout <= final carry.
    - ovf <= carry_in_to_MSB ^ final carry. carry_in_to_MSB is the carry register value before this last edge.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency: start sampled at edge k gives busy=1 for cycles k+1..k+WIDTH and done=1 in the cycle after edge k+WIDTH. Minimum restart spacing is WIDTH+2 cycles.
- busy is a decode of state==RUN; done is a decode of state==DONE. Both are glitch-free registered-state decodes.
- start while in RUN or DONE: ignored, with no queuing and no effect on the operation in flight. a, b and cin may change freely after acceptance.
- sum/cout/ovf hold their last values until the next DONE entry. An accepted start does not clear them.
- WIDTH=1: a single RUN cycle. ovf = cin ^ cout.
- Counter width is clog2(WIDTH)+1 bits; there is no wrap inside RUN.

Test Plan:
- WIDTH=8: a=8'h5A, b=8'h3C, cin=0, start pulse -> busy high 8 cycles; done one cycle later; sum=8'h96, cout=0, ovf=1.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
- WIDTH=8: a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0, ovf=0. Start pulses on cycles 3 and 8 of busy -> ignored; exactly one done; outputs unchanged from this result.
- Reset mid-operation: start with a=8'h12, b=8'h34; assert rst at 4th busy cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, and no done pulse follows. A fresh start then produces sum=8'h46.
- Self-checking loop, WIDTH=8: 200 random {a,b,cin} via $random, each compared against reference {cout,sum}=a+b+cin and ovf=(a[7]==b[7])&&(sum[7]!=a[7]). Mismatches are reported with $display and $time, and the error count must be 0 at $finish.
- WIDTH=1 instance: all 8 {a,b,cin} combinations -> sum/cout match the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1, ovf=0). done arrives 2 cycles after start sampling.
